count_sequencer: RTL

- Controller that shares the single seconds countdown counter between two requesters, A and B.
- Arbitrates round-robin and loads the granted requester's duration onto counterSeconds.
- Pulses beginCount for one cycle, waits for the counter's countDone, then returns a one-cycle done pulse to the owner.
- Sits between the lab control FSMs and the counter block.

---
 rtl/count_sequencer_pkg.sv | 26 ++
 rtl/count_sequencer_if.sv | 33 +++
 rtl/count_sequencer_rr_arbiter2.sv | 26 ++
 rtl/count_sequencer.sv | 98 +++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// count_pkg: shared types and constants for the count sequencer slice.
//   CNT_W    : default width of duration buses and counterSeconds
//   state_t  : sequencer FSM states
//   req_id_t : requester identity (A or B)
package count_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // The requester that is not `id`; used for the round-robin tie-break.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: bundle between the two requesters / the seconds counter
// and the count sequencer.
//   master : requester and counter side (drives req/dur/countDone)
//   slave  : sequencer side (drives beginCount, counterSeconds, grants, dones, busy)
interface count_sequencer_if #(
  parameter int CNT_W = count_pkg::CNT_W
);

  logic             reqA;
  logic [CNT_W-1:0] durA;
  logic             reqB;
  logic [CNT_W-1:0] durB;
  logic             countDone;

  logic             beginCount;
  logic [CNT_W-1:0] counterSeconds;
  logic             grantA;
  logic             grantB;
  logic             doneA;
  logic             doneB;
  logic             busy;

  modport master (
    output reqA, durA, reqB, durB, countDone,
    input  beginCount, counterSeconds, grantA, grantB, doneA, doneB, busy
  );

  modport slave (
    input  reqA, durA, reqB, durB, countDone,
    output beginCount, counterSeconds, grantA, grantB, doneA, doneB, busy
  );

endinterface

// File: rtl/count_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, purely combinational.
//   i_req_a, i_req_b : request levels
//   i_last_served    : requester granted most recently (state lives in the caller)
//   o_grant_vld      : at least one request present
//   o_winner         : requester to grant; on a tie, the one not last served
module rr_arbiter2
  import count_pkg::*;
(
  input  logic    i_req_a,
  input  logic    i_req_b,
  input  req_id_t i_last_served,
  output logic    o_grant_vld,
  output req_id_t o_winner
);

  always_comb begin
    o_grant_vld = i_req_a | i_req_b;
    o_winner    = REQ_A;
    if (i_req_a && i_req_b) begin
      o_winner = other_id(i_last_served);
    end else if (i_req_b) begin
      o_winner = REQ_B;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: shares one seconds countdown counter between requesters A
// and B. Arbitrates round-robin, latches the winner's duration onto
// counterSeconds, strobes beginCount, waits for countDone and returns a
// one-cycle done pulse to the owner.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_seq  : request / counter bundle (slave side)
//
// state | meaning
// IDLE  | no owner; arbitrate on requests sampled at the clock edge
// ISSUE | one cycle; beginCount high, countDone ignored
// RUN   | counter running; wait for countDone
// DONE  | one cycle; done pulse to owner, grant still high
module count_sequencer
  import count_pkg::*;
#(
  parameter int CNT_W = count_pkg::CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  count_sequencer_if.slave   io_seq
);

  state_t           r_state;
  state_t           w_state_nxt;
  req_id_t          r_owner;
  req_id_t          w_owner_nxt;
  req_id_t          r_last_served;
  req_id_t          w_last_nxt;
  logic [CNT_W-1:0] r_cnt_sec;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_grant_vld;
  req_id_t          w_winner;
  logic [CNT_W-1:0] w_dur_sel;

  rr_arbiter2 u_arb (
    .i_req_a       (io_seq.reqA),
    .i_req_b       (io_seq.reqB),
    .i_last_served (r_last_served),
    .o_grant_vld   (w_grant_vld),
    .o_winner      (w_winner)
  );

  assign w_dur_sel = (w_winner == REQ_A) ? io_seq.durA : io_seq.durB;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_served;
    w_cnt_nxt   = r_cnt_sec;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_owner_nxt = w_winner;
          w_last_nxt  = w_winner;
          w_cnt_nxt   = w_dur_sel;
          // A zero duration never touches the counter.
          w_state_nxt = (w_dur_sel == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: w_state_nxt = RUN;
      RUN: begin
        if (io_seq.countDone) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset leaves lastServed at B so that A wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_owner       <= REQ_A;
      r_last_served <= REQ_B;
      r_cnt_sec     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last_served <= w_last_nxt;
      r_cnt_sec     <= w_cnt_nxt;
    end
  end

  // Outputs decode only registered state, so reset clears them immediately
  // and no input reaches an output combinationally.
  assign io_seq.beginCount     = (r_state == ISSUE);
  assign io_seq.busy           = (r_state != IDLE);
  assign io_seq.grantA         = (r_state != IDLE) && (r_owner == REQ_A);
  assign io_seq.grantB         = (r_state != IDLE) && (r_owner == REQ_B);
  assign io_seq.doneA          = (r_state == DONE) && (r_owner == REQ_A);
  assign io_seq.doneB          = (r_state == DONE) && (r_owner == REQ_B);
  assign io_seq.counterSeconds = r_cnt_sec;

endmodule
